// File: rtl/elixirchip_es1_spu_pkg.sv
// Shared types and helpers for the SPU op arbiter slice.
// Round-robin pick is written for up to MAX_REQ requesters.
package elixirchip_es1_spu_pkg;

  localparam int MAX_REQ = 16;

  typedef logic [$clog2(MAX_REQ)-1:0] req_id_t;

  function automatic int id_bits(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] vld,
    input req_id_t            ptr,
    input int                 n
  );
    logic [MAX_REQ-1:0] g;
    logic               hit;
    int                 idx;
    req_id_t            ix;
    g   = '0;
    hit = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= n) idx = idx - n;
      ix = req_id_t'(idx);
      if (k < n && !hit && vld[ix]) begin
        g[ix] = 1'b1;
        hit   = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/elixirchip_es1_spu_rr_arbiter.sv
// Round-robin arbiter; pointer moves past the winner on each
// enabled transfer and restarts at requester 0 on reset.
module elixirchip_es1_spu_rr_arbiter
  import elixirchip_es1_spu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_BITS = id_bits(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cke,
  input  logic [NUM_REQ-1:0] valid_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_BITS-1:0] id_o
);

  logic [ID_BITS-1:0] ptr_q;
  logic [ID_BITS-1:0] ptr_d;
  logic [MAX_REQ-1:0] vld_ext;
  logic [MAX_REQ-1:0] pick;

  always_comb begin
    vld_ext = '0;
    vld_ext[NUM_REQ-1:0] = valid_i;
    pick    = rr_pick(vld_ext, req_id_t'(ptr_q), NUM_REQ);
    grant_o = pick[NUM_REQ-1:0];
    id_o    = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (pick[i]) id_o = ID_BITS'(i);
    end
    ptr_d = ptr_q;
    if (cke && !reset && |valid_i) begin
      ptr_d = (id_o == ID_BITS'(NUM_REQ-1)) ? '0
            : id_o + ID_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/elixirchip_es1_spu_op_arbiter.sv
// Shares one SPU op unit among NUM_REQ requesters; the requester
// id rides a LATENCY-deep tag pipe alongside the op unit.
module elixirchip_es1_spu_op_arbiter
  import elixirchip_es1_spu_pkg::*;
#(
  parameter int    NUM_REQ    = 4,
  parameter int    ID_BITS    = id_bits(NUM_REQ),
  parameter int    LATENCY    = 1,
  parameter int    DATA_BITS  = 8,
  parameter type   data_t     = logic [DATA_BITS-1:0],
  parameter string DEVICE     = "RTL",
  parameter string SIMULATION = "false",
  parameter string DEBUG      = "false"
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cke,
  input  data_t [NUM_REQ-1:0] s_data0,
  input  data_t [NUM_REQ-1:0] s_data1,
  input  logic  [NUM_REQ-1:0] s_clear,
  input  logic  [NUM_REQ-1:0] s_valid,
  output logic  [NUM_REQ-1:0] s_ready,
  output data_t               m_op_data0,
  output data_t               m_op_data1,
  output logic                m_op_clear,
  output logic                m_op_valid,
  input  data_t               s_op_data,
  output logic  [ID_BITS-1:0] m_id,
  output data_t               m_data,
  output logic                m_valid
);

  logic [NUM_REQ-1:0] grant;
  logic [ID_BITS-1:0] gid;
  logic               xfer;

  elixirchip_es1_spu_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_BITS (ID_BITS)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .cke     (cke),
    .valid_i (s_valid),
    .grant_o (grant),
    .id_o    (gid)
  );

  assign s_ready = (cke && !reset) ? grant : '0;
  assign xfer    = |(s_valid & s_ready);

  data_t              d0_q, d0_d;
  data_t              d1_q, d1_d;
  logic               clr_q, clr_d;
  logic               vld_q, vld_d;
  logic [ID_BITS-1:0] oid_q, oid_d;

  always_comb begin
    d0_d  = d0_q;
    d1_d  = d1_q;
    clr_d = 1'b0;
    vld_d = 1'b0;
    oid_d = oid_q;
    if (xfer) begin
      d0_d  = s_data0[gid];
      d1_d  = s_data1[gid];
      clr_d = s_clear[gid];
      vld_d = 1'b1;
      oid_d = gid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d0_q  <= '0;
      d1_q  <= '0;
      clr_q <= 1'b0;
      vld_q <= 1'b0;
      oid_q <= '0;
    end else if (cke) begin
      d0_q  <= d0_d;
      d1_q  <= d1_d;
      clr_q <= clr_d;
      vld_q <= vld_d;
      oid_q <= oid_d;
    end
  end

  assign m_op_data0 = d0_q;
  assign m_op_data1 = d1_q;
  assign m_op_clear = clr_q;
  assign m_op_valid = vld_q;

  logic [LATENCY-1:0]              tvld_q, tvld_d;
  logic [LATENCY-1:0][ID_BITS-1:0] tid_q, tid_d;

  always_comb begin
    tvld_d = tvld_q;
    tid_d  = tid_q;
    for (int i = LATENCY-1; i > 0; i--) begin
      tvld_d[i] = tvld_q[i-1];
      tid_d[i]  = tid_q[i-1];
    end
    tvld_d[0] = vld_q | clr_q;
    tid_d[0]  = oid_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tvld_q <= '0;
      tid_q  <= '0;
    end else if (cke) begin
      tvld_q <= tvld_d;
      tid_q  <= tid_d;
    end
  end

  assign m_valid = tvld_q[LATENCY-1];
  assign m_id    = tid_q[LATENCY-1];
  assign m_data  = s_op_data;

  // Grant must stay one-hot; only elaborated in debug/simulation builds.
  if (SIMULATION == "true" || DEBUG == "true" || DEVICE == "SIM") begin : g_chk
    always_ff @(posedge clk) begin
      if (!reset) assert ($onehot0(s_ready));
    end
  end

endmodule
